// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and a small window-decode helper
// used by the VGA sync counter and the display top level.
package vga_pkg;
   localparam int CW       = 10;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int BORDER   = 10;

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef logic [CW-1:0] count_t;

   // Inclusive window test on an unsigned counter value.
   function automatic logic in_window(input count_t value, input count_t lo, input count_t hi);
      return (value >= lo) && (value <= hi);
   endfunction
endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical pixel counters with zero-latency hsync, vsync and
// active-area decode; outputs held inactive while reset is low.
module vga_sync_counter #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   active,
   output logic [vga_pkg::CW-1:0] hcounter,
   output logic [vga_pkg::CW-1:0] vcounter
);
   import vga_pkg::*;

   localparam int H_TOTAL_L = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL_L = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START  = H_ACTIVE + H_FP;
   localparam int HS_END    = HS_START + H_SYNC - 1;
   localparam int VS_START  = V_ACTIVE + V_FP;
   localparam int VS_END    = VS_START + V_SYNC - 1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         hcounter <= '0;
         vcounter <= '0;
      end else if (hcounter == CW'(H_TOTAL_L - 1)) begin
         hcounter <= '0;
         vcounter <= (vcounter == CW'(V_TOTAL_L - 1)) ? '0 : vcounter + CW'(1);
      end else begin
         hcounter <= hcounter + CW'(1);
      end
   end

   always_comb begin
      hsync  = 1'b1;
      vsync  = 1'b1;
      active = 1'b0;
      if (reset) begin
         hsync  = !in_window(hcounter, CW'(HS_START), CW'(HS_END));
         vsync  = !in_window(vcounter, CW'(VS_START), CW'(VS_END));
         active = (hcounter < CW'(H_ACTIVE)) && (vcounter < CW'(V_ACTIVE));
      end
   end
endmodule

// File: rtl/vga_display.sv
// 640x480 VGA display: sync timing plus a white border framing an
// 8-pixel repeating pattern serialised MSB-first from `pixels`.
module vga_display #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter int BORDER   = vga_pkg::BORDER
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             pixels,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   video,
   output logic                   active,
   output logic [vga_pkg::CW-1:0] hcounter,
   output logic [vga_pkg::CW-1:0] vcounter
);
   import vga_pkg::*;

   logic border;

   vga_sync_counter #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .hsync    (hsync),
      .vsync    (vsync),
      .active   (active),
      .hcounter (hcounter),
      .vcounter (vcounter)
   );

   always_comb begin
      border = (hcounter < CW'(BORDER)) || (hcounter >= CW'(H_ACTIVE - BORDER)) ||
               (vcounter < CW'(BORDER)) || (vcounter >= CW'(V_ACTIVE - BORDER));
      // Column bits [2:0] select pixels[7 - col], i.e. the bitwise inverse.
      video  = active && (border || pixels[~hcounter[2:0]]);
   end
endmodule

// File: tb/tb_vga_display.sv
// Directed bench for vga_display: reset, line/frame timing, border and
// pattern serialisation, mid-frame reset. A short-frame instance covers vsync/wrap.
module tb_vga_display;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] pixels = 8'h00;
   logic       hsync, vsync, video, active;
   logic [9:0] hcounter, vcounter;
   logic       s_hsync, s_vsync, s_video, s_active;
   logic [9:0] s_hcounter, s_vcounter;

   int compared = 0;
   int mismatched = 0;
   int fall, rise, low, s_low, act, vone, vone5, last1, first0;
   logic [9:0] v_before;
   logic       vid [0:799];
   logic [15:0] wl, wr;
   logic [7:0]  w8, w0;

   always #20 clk = ~clk;

   vga_display dut (
      .clk(clk), .reset(reset), .pixels(pixels), .hsync(hsync), .vsync(vsync),
      .video(video), .active(active), .hcounter(hcounter), .vcounter(vcounter)
   );

   // Same horizontal timing, 27-line frame (vsync on lines 22-23).
   vga_display #(.V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_small (
      .clk(clk), .reset(reset), .pixels(pixels), .hsync(s_hsync), .vsync(s_vsync),
      .video(s_video), .active(s_active), .hcounter(s_hcounter), .vcounter(s_vcounter)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_h"},     32'(hcounter), 0);
      check({tag, "_v"},     32'(vcounter), 0);
      check({tag, "_hsync"}, 32'(hsync), 1);
      check({tag, "_vsync"}, 32'(vsync), 1);
      check({tag, "_video"}, 32'(video), 0);
      check({tag, "_active"}, 32'(active), 0);
   endtask

   initial begin
      fall = -1; rise = -1; low = 0; s_low = 0; act = 0; vone = 0;
      vone5 = 0; last1 = -1; first0 = -1; v_before = '1;

      step(3);
      check_reset_state("rst");
      reset = 1'b1;
      step(1);
      $display("release: h=%0d v=%0d", hcounter, vcounter);
      check("rel_h", 32'(hcounter), 1);
      check("rel_v", 32'(vcounter), 0);
      check("small_video_l0", 32'(s_video), 1);

      for (int i = 1; i < 800; i++) begin
         if (!hsync) begin
            low++;
            if (fall < 0) fall = i;
         end else if (fall >= 0 && rise < 0) begin
            rise = i;
         end
         if (!s_hsync) s_low++;
         act  += int'(active);
         vone += int'(video);
         if (i == 799) v_before = vcounter;
         step(1);
      end
      $display("line0: hsync fall=%0d rise=%0d low=%0d active=%0d", fall, rise, low, act);
      check("hs_fall", 32'(fall), 656);
      check("hs_rise", 32'(rise), 752);
      check("hs_low", 32'(low), 96);
      check("small_hs_low", 32'(s_low), 96);
      check("act_l0", 32'(act), 639);
      check("video_l0", 32'(vone), 639);
      check("v_at_799", 32'(v_before), 0);
      check("wrap_h", 32'(hcounter), 0);
      check("wrap_v", 32'(vcounter), 1);

      step(3200);
      for (int i = 0; i < 800; i++) begin
         if (video) begin
            vone5++;
            last1 = i;
         end else if (first0 < 0) begin
            first0 = i;
         end
         step(1);
      end
      $display("line5: video ones=%0d last=%0d first0=%0d", vone5, last1, first0);
      check("l5_ones", 32'(vone5), 640);
      check("l5_last1", 32'(last1), 639);
      check("l5_first0", 32'(first0), 640);

      step(2500);
      check("l9_v", 32'(dut.u_sync.vcounter), 9);
      check("l9_video", 32'(video), 1);
      step(800);
      check("l10_video_p0", 32'(video), 0);
      pixels = 8'hFF;
      #1;
      check("l10_video_pff", 32'(video), 1);
      pixels = 8'b0011_1100;

      step(9499);
      $display("small l21: vsync=%0d active=%0d", s_vsync, s_active);
      check("s_l21_vsync", 32'(s_vsync), 1);
      check("s_l21_active", 32'(s_active), 0);
      check("l21_vsync", 32'(vsync), 1);
      step(1);
      check("s_l22_v", 32'(s_vcounter), 22);
      check("s_l22_vsync", 32'(s_vsync), 0);
      step(1599);
      check("s_l23_vsync", 32'(s_vsync), 0);
      step(1);
      check("s_l24_vsync", 32'(s_vsync), 1);
      step(2399);
      check("s_end_v", 32'(s_vcounter), 26);
      check("s_end_h", 32'(s_hcounter), 799);
      step(1);
      $display("small wrap: h=%0d v=%0d main v=%0d", s_hcounter, s_vcounter, vcounter);
      check("s_wrap_v", 32'(s_vcounter), 0);
      check("s_wrap_h", 32'(s_hcounter), 0);
      check("main_v27", 32'(vcounter), 27);

      step(2400);
      for (int i = 0; i < 800; i++) begin
         vid[i] = video;
         step(1);
      end
      for (int k = 0; k < 16; k++) begin
         wl[15-k] = vid[8+k];
         wr[15-k] = vid[624+k];
      end
      for (int k = 0; k < 8; k++) begin
         w8[7-k] = vid[24+k];
         w0[7-k] = vid[k];
      end
      $display("line30: left=%h rep=%h right=%h first=%h", wl, w8, wr, w0);
      check("l30_left", 32'(wl), 32'hFC3C);
      check("l30_repeat", 32'(w8), 32'h3C);
      check("l30_right", 32'(wr), 32'h3FFF);
      check("l30_first8", 32'(w0), 32'hFF);
      check("l30_h640", 32'(vid[640]), 0);
      check("l31_h", 32'(hcounter), 0);
      check("l31_v", 32'(vcounter), 31);

      step(100);
      check("pre_rst_h", 32'(hcounter), 100);
      reset = 1'b0;
      step(1);
      $display("mid-frame reset: h=%0d v=%0d", hcounter, vcounter);
      check_reset_state("midrst");
      reset = 1'b1;
      step(1);
      check("resume_h", 32'(hcounter), 1);
      check("resume_v", 32'(vcounter), 0);
      step(799);
      check("resume_wrap_h", 32'(hcounter), 0);
      check("resume_wrap_v", 32'(vcounter), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/vga_display.md
Name: vga_display

Overview:
- 640x480 @ 60 Hz VGA timing generator with a 1-bit video output. Clock `clk` is the 25.175 MHz pixel clock, one pixel per cycle.
- Generates horizontal and vertical counters and negative-polarity hsync/vsync.
- Inside the active area it draws a fixed 10-pixel white border. Within the border it serialises an 8-bit `pixels` pattern MSB-first, repeating every 8 columns.
- Sits between the frame/pattern source and the VGA connector DAC/resistor network.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- BORDER, 10, border thickness in pixels/lines

Ports:
- clk  input  1  pixel clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- pixels  input  8  pattern byte, sampled combinationally each cycle
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- video  output  1  pixel colour (1 = lit)
- active  output  1  high while in the visible area
- hcounter  output  10  current column, 0..799
- vcounter  output  10  current line, 0..524

Behaviour:
- Internal registers are named `hcounter` and `vcounter`. Benches probe `vcounter` hierarchically.
- H_TOTAL = 800 and V_TOTAL = 525, derived from the parameters.
- Reset (reset==0 at a rising edge): hcounter=0 and vcounter=0.
  - While reset is held: hsync=1, vsync=1, video=0, active=0.
  - Reset asserted mid-frame restarts at (0,0) on the next edge.
- Counting:
  - hcounter increments every clock.
  - At H_TOTAL-1 it wraps to 0 and vcounter increments.
  - vcounter wraps from V_TOTAL-1 to 0 on the same edge that hcounter wraps.
  - Frame length is 420000 clocks.
- hsync, vsync, active and video are combinational decodes of the registered counters (zero latency relative to the counters), gated to their inactive values during reset.
- hsync = 0 iff 656 <= hcounter <= 751. Otherwise 1.
- vsync = 0 iff 490 <= vcounter <= 491. Otherwise 1.
- active = (hcounter < 640) && (vcounter < 480).
- video:
  - 0 when not active.
  - 1 when active and any of: hcounter < BORDER, hcounter >= 640-BORDER, vcounter < BORDER, vcounter >= 480-BORDER.
  - Otherwise pixels[7 - hcounter[2:0]].
- Width rules: comparisons are unsigned 10-bit. No counter value outside the stated ranges ever occurs.

Decomposition:
- Shared package vga_pkg holds the timing constants (H_ACTIVE … V_BP, H_TOTAL, V_TOTAL, BORDER) and derived sync start/end values.
- One sub-module: vga_sync_counter, holding the h/v counters plus hsync/vsync/active decode.
- The top level adds the border and pattern mux.

Test Plan:
- Hold reset=0 for 3 clocks, then release -> during reset hcounter=0, vcounter=0, hsync=1, vsync=1, video=0. First edge after release gives hcounter=1.
- Free-run one line -> hsync falls at hcounter=656 and rises at 752 (96 clocks low). vcounter goes 0→1 when hcounter wraps 799→0.
- Free-run one frame -> vsync low exactly for lines 490–491 (1600 clocks). vcounter wraps 524→0 after 420000 clocks.
- Border check on line 5 -> video=1 for all hcounter 0..639 and 0 for 640..799. On line 30: video=1 at hcounter 0..9 and 630..639.
- pixels=8'b00111100 on line 30, hcounter 16..23 -> video sequence 0,0,1,1,1,1,0,0. The same pattern repeats at hcounter 24..31.
- Assert reset at vcounter=30, hcounter=100 -> next edge gives hcounter=0, vcounter=0. After release, counting resumes normally.
